lsu_bank_arb: RTL

LSU_BANK_ARB -- requirements
Module: lsu_bank_arb

---
 rtl/lsu_bank_arb_pkg.sv | 13 +
 rtl/lsu_bank_arb_rr_arbiter.sv | 30 +++
 rtl/lsu_bank_arb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu_bank_arb_pkg.sv
// Shared constants and FSM encoding for the LSU bank arbiter.
package lsu_bank_arb_pkg;

    localparam int A_W       = 16;
    localparam int D_W       = 32;
    localparam int N_LSU_DEF = 4;

    typedef enum logic {
        ARB   = 1'b0,
        WR2RD = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_bank_arb_rr_arbiter.sv
// Round-robin priority search: the first requester after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    int idx;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        // Walk from the farthest candidate to the nearest so the nearest requester overwrites.
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/lsu_bank_arb.sv
// Shares one memory bank among N_LSU load/store units with round-robin grants.
// Build macro LSU_BANK_ARB_STATS_EN adds the stall-cycle counter on stall_cnt.
module lsu_bank_arb
    import lsu_bank_arb_pkg::*;
#(
    parameter int N_LSU = N_LSU_DEF,
    parameter int A_W   = lsu_bank_arb_pkg::A_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LSU-1:0]   req_ren,
    input  logic [N_LSU-1:0]   req_wen,
    input  logic [N_LSU*A_W-1:0] req_addr,
    input  logic [N_LSU*32-1:0]  req_wdata,
    output logic [N_LSU-1:0]   grant,
    output logic [N_LSU-1:0]   rvalid,
    output logic [31:0]        rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [A_W-1:0]     mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        stall_cnt
);

    localparam int IDX_W = $clog2(N_LSU);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, hold_idx;
    logic [A_W-1:0]     hold_addr;
    logic [N_LSU-1:0]   req_any, arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               cmd_en, cmd_we, cmd_rd;
    logic [A_W-1:0]     cmd_addr;
    logic [31:0]        cmd_wdata;
    logic [IDX_W-1:0]   cmd_tag;
    logic               rd_v1;
    logic [IDX_W-1:0]   rd_tag1;

    assign req_any = req_ren | req_wen;

    rr_arbiter #(.N(N_LSU), .IDX_W(IDX_W)) u_rr (
        .req     (req_any),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Grant is gated by rst so it drops in the same instant the registers clear.
    always_comb begin
        state_nxt = state;
        grant     = '0;
        cmd_en    = 1'b0;
        cmd_we    = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = req_addr[arb_idx*A_W +: A_W];
        cmd_wdata = req_wdata[arb_idx*32 +: 32];
        cmd_tag   = arb_idx;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (|arb_gnt) begin
                        grant  = arb_gnt;
                        cmd_en = 1'b1;
                        cmd_we = req_wen[arb_idx];
                        cmd_rd = !req_wen[arb_idx];
                        if (req_wen[arb_idx] && req_ren[arb_idx])
                            state_nxt = WR2RD;
                    end
                end
                WR2RD: begin
                    // Read back the address just written; the LSU keeps the bank a second cycle.
                    grant[hold_idx] = 1'b1;
                    cmd_en          = 1'b1;
                    cmd_rd          = 1'b1;
                    cmd_addr        = hold_addr;
                    cmd_tag         = hold_idx;
                    state_nxt       = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= IDX_W'(N_LSU - 1);
            hold_idx  <= '0;
            hold_addr <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_v1     <= 1'b0;
            rd_tag1   <= '0;
            rvalid    <= '0;
            rdata     <= 32'hFFFF_FFFF;
        end else begin
            state  <= state_nxt;
            mem_en <= cmd_en;
            mem_we <= cmd_we;
            if (cmd_en) mem_addr <= cmd_addr;
            if (cmd_we) mem_wdata <= cmd_wdata;
            if (state == ARB && |arb_gnt) begin
                ptr       <= arb_idx;
                hold_idx  <= arb_idx;
                hold_addr <= cmd_addr;
            end
            // Bank data is sampled at the end of the command cycle, giving grant-to-rvalid of two.
            rd_v1   <= cmd_rd;
            if (cmd_rd) rd_tag1 <= cmd_tag;
            rvalid  <= rd_v1 ? (N_LSU'(1) << rd_tag1) : '0;
            if (rd_v1) rdata <= mem_rdata;
        end
    end

`ifdef LSU_BANK_ARB_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (|(req_any & ~grant) && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
